// File: rtl/memory_responder_if.sv
// Initiator/responder bus for memory_responder: request fields in, registered response out.
interface memory_responder_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        size;
    logic [1:0]  prot;
    logic [1:0]  trans;
    logic [31:0] rdata;
    logic        abort;
    logic        ready;

    modport master (
        output addr, wdata, write, size, prot, trans,
        input  rdata, abort, ready
    );

    modport slave (
        input  addr, wdata, write, size, prot, trans,
        output rdata, abort, ready
    );
endinterface

// File: rtl/memory_responder.sv
// Single-port word memory behind a request/ready bus with configurable wait states,
// range/alignment/privilege checking and registered responses.
module memory_responder #(
    parameter int unsigned DEPTH       = 8192,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] PROT_BASE   = 32'h4000
) (
    input  logic              clk,
    input  logic              n_reset,
    memory_responder_if.slave bus
);
    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WaitInit = WAIT_STATES[3:0];

    typedef enum logic [1:0] {StIdle, StWait, StData, StErr} state_e;

    state_e            r_state, w_state_d;
    logic [3:0]        r_cnt, w_cnt_d;
    logic [IdxW-1:0]   r_idx;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    logic              r_write;
    logic              r_size;
    logic [31:0]       r_rdata;
    logic              r_abort;
    logic              r_ready;
    logic [31:0]       r_mem [DEPTH];

    logic              w_req;
    logic              w_err;
    logic              w_capture;
    logic [IdxW-1:0]   w_idx;
    logic [1:0]        w_lane;
    logic [31:0]       w_wdata;
    logic              w_write;
    logic              w_size;
    logic              w_mem_we;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_rd_val;
    logic              w_unused;

    assign w_unused = ^{bus.trans[0], bus.prot[0]};

    // A request in the ready-strobe cycle is deliberately ignored.
    assign w_req = bus.trans[1] && !r_ready;
    assign w_err = ({2'b00, bus.addr[31:2]} >= DEPTH)
                || (bus.size && (bus.addr[1:0] != 2'b00))
                || (bus.write && !bus.prot[1] && (bus.addr >= PROT_BASE));

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_capture = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    if (w_err) begin
                        w_state_d = StErr;
                    end else if (WAIT_STATES == 0) begin
                        w_state_d = StData;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                w_cnt_d = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_d = StData;
                end
            end
            StData:  w_state_d = StIdle;
            StErr:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Zero-wait writes commit on the sampling edge, so take fields straight from the bus.
    always_comb begin
        if (r_state == StIdle) begin
            w_idx   = bus.addr[IdxW+1:2];
            w_lane  = bus.addr[1:0];
            w_wdata = bus.wdata;
            w_write = bus.write;
            w_size  = bus.size;
        end else begin
            w_idx   = r_idx;
            w_lane  = r_lane;
            w_wdata = r_wdata;
            w_write = r_write;
            w_size  = r_size;
        end
        w_mem_we = n_reset && w_write && (w_state_d == StData) && (r_state != StData);
    end

    always_comb begin
        w_rd_word = r_mem[r_idx];
        if (r_size) begin
            w_rd_val = w_rd_word;
        end else begin
            w_rd_val = {24'h0, w_rd_word[{r_lane, 3'b000} +: 8]};
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_lane  <= 2'b00;
            r_wdata <= 32'h0;
            r_write <= 1'b0;
            r_size  <= 1'b0;
            r_rdata <= 32'h0;
            r_abort <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_capture) begin
                r_idx   <= bus.addr[IdxW+1:2];
                r_lane  <= bus.addr[1:0];
                r_wdata <= bus.wdata;
                r_write <= bus.write;
                r_size  <= bus.size;
            end
            r_ready <= (r_state == StData) || (r_state == StErr);
            r_abort <= (r_state == StErr);
            if ((r_state == StData) && !r_write) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    // Storage has no reset so contents survive n_reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            if (w_size) begin
                r_mem[w_idx] <= w_wdata;
            end else begin
                r_mem[w_idx][{w_lane, 3'b000} +: 8] <= w_wdata[7:0];
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.abort = r_abort;
    assign bus.ready = r_ready;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (WAIT_STATES 1, 3, 0) driven from a vector
// table with a response scoreboard, plus hand-written reset and busy/back-to-back sequences.
module tb_memory_responder;
    localparam int unsigned DEPTH = 8192;

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic        size;
        logic [1:0]  prot;
        logic        exp_abort;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    typedef struct {
        logic        abort;
        logic [31:0] rdata;
        int          lat;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [31:0] d_addr  [3];
    logic [31:0] d_wdata [3];
    logic        d_write [3];
    logic        d_size  [3];
    logic [1:0]  d_prot  [3];
    logic [1:0]  d_trans [3];
    logic [31:0] q_rdata [3];
    logic        q_abort [3];
    logic        q_ready [3];

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        memory_responder_if bus ();
        assign bus.addr  = d_addr[g];
        assign bus.wdata = d_wdata[g];
        assign bus.write = d_write[g];
        assign bus.size  = d_size[g];
        assign bus.prot  = d_prot[g];
        assign bus.trans = d_trans[g];
        assign q_rdata[g] = bus.rdata;
        assign q_abort[g] = bus.abort;
        assign q_ready[g] = bus.ready;

        memory_responder #(
            .DEPTH       (DEPTH),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
            .PROT_BASE   (32'h4000)
        ) u_dut (
            .clk     (clk),
            .n_reset (rst_n[g]),
            .bus     (bus)
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        int   lat;
        bit   seen;
        int   k;
        k = v.k;
        @(negedge clk);
        d_addr[k]  = v.addr;
        d_wdata[k] = v.wdata;
        d_write[k] = v.write;
        d_size[k]  = v.size;
        d_prot[k]  = v.prot;
        d_trans[k] = 2'b10;
        e.abort = v.exp_abort;
        e.rdata = v.exp_rdata;
        e.lat   = v.exp_abort ? 1 : 1 + ws_of(k);
        e.name  = v.name;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        d_trans[k] = 2'b00;
        lat  = 0;
        seen = q_ready[k];
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = q_ready[k];
        end
        e = sb.pop_front();
        chk({e.name, " ready"}, 32'(seen), 32'd1);
        chk({e.name, " latency"}, lat, e.lat);
        chk({e.name, " abort"}, 32'(q_abort[k]), 32'(e.abort));
        chk({e.name, " rdata"}, q_rdata[k], e.rdata);
        @(posedge clk);
        @(negedge clk);
        chk({e.name, " strobe"}, {30'd0, q_ready[k], q_abort[k]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 3'b000;
        for (int i = 0; i < 3; i++) begin
            d_addr[i]  = 32'h0;
            d_wdata[i] = 32'h0;
            d_write[i] = 1'b0;
            d_size[i]  = 1'b0;
            d_prot[i]  = 2'b00;
            d_trans[i] = 2'b00;
        end

        // k, addr, wdata, write, size, prot, exp_abort, exp_rdata, name
        tbl.push_back('{0, 32'h10,   32'hDEADBEEF, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0,        "w1 wr 10"});
        tbl.push_back('{0, 32'h10,   32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 32'hDEADBEEF, "w1 rd 10"});
        tbl.push_back('{0, 32'h20,   32'h11223344, 1'b1, 1'b1, 2'b00, 1'b0, 32'hDEADBEEF, "w1 wr 20"});
        tbl.push_back('{0, 32'h22,   32'h123456AA, 1'b1, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF, "w1 wrb 22"});
        tbl.push_back('{0, 32'h20,   32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 32'h11AA3344, "w1 rd 20"});
        tbl.push_back('{0, 32'h23,   32'h0,        1'b0, 1'b0, 2'b00, 1'b0, 32'h00000011, "w1 rdb 23"});
        tbl.push_back('{0, 32'h21,   32'h0,        1'b0, 1'b1, 2'b00, 1'b1, 32'h00000011, "w1 misalign"});
        tbl.push_back('{0, 32'h8000, 32'h0,        1'b0, 1'b1, 2'b00, 1'b1, 32'h00000011, "w1 range"});
        tbl.push_back('{0, 32'h8000, 32'h0,        1'b0, 1'b0, 2'b00, 1'b1, 32'h00000011, "w1 rangeb"});
        tbl.push_back('{0, 32'h4000, 32'hCAFEF00D, 1'b1, 1'b1, 2'b00, 1'b1, 32'h00000011, "w1 user wr"});
        tbl.push_back('{0, 32'h4000, 32'hCAFEF00D, 1'b1, 1'b1, 2'b10, 1'b0, 32'h00000011, "w1 priv wr"});
        tbl.push_back('{0, 32'h4000, 32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 32'hCAFEF00D, "w1 rd 4000"});
        tbl.push_back('{0, 32'h4001, 32'h0,        1'b0, 1'b0, 2'b00, 1'b0, 32'h000000F0, "w1 rdb 4001"});
        tbl.push_back('{0, 32'h3FFC, 32'h01020304, 1'b1, 1'b1, 2'b00, 1'b0, 32'h000000F0, "w1 wr 3ffc"});
        tbl.push_back('{0, 32'h3FFC, 32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 32'h01020304, "w1 rd 3ffc"});
        tbl.push_back('{0, 32'h7FFF, 32'h0000005C, 1'b1, 1'b0, 2'b10, 1'b0, 32'h01020304, "w1 wrb 7fff"});
        tbl.push_back('{0, 32'h7FFF, 32'h0,        1'b0, 1'b0, 2'b00, 1'b0, 32'h0000005C, "w1 rdb 7fff"});
        tbl.push_back('{1, 32'h40,   32'h0BADF00D, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0,        "w3 wr 40"});
        tbl.push_back('{1, 32'h40,   32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 32'h0BADF00D, "w3 rd 40"});
        tbl.push_back('{2, 32'h8,    32'h5A5A0001, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0,        "w0 wr 8"});

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset rdata %0d", i), q_rdata[i], 32'h0);
            chk($sformatf("reset flags %0d", i), {30'd0, q_ready[i], q_abort[i]}, 32'd0);
        end
        rst_n = 3'b111;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) issue(tbl[i]);

        // Reset in WAIT discards a pending write to 0x40.
        @(negedge clk);
        d_addr[1]  = 32'h40;
        d_wdata[1] = 32'h12345678;
        d_write[1] = 1'b1;
        d_size[1]  = 1'b1;
        d_trans[1] = 2'b10;
        @(posedge clk);
        @(negedge clk);
        d_trans[1] = 2'b00;
        @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        chk("w3 rst rdata", q_rdata[1], 32'h0);
        chk("w3 rst flags", {30'd0, q_ready[1], q_abort[1]}, 32'd0);
        repeat (3) @(negedge clk);
        chk("w3 rst held", {30'd0, q_ready[1], q_abort[1]}, 32'd0);
        rst_n[1] = 1'b1;
        @(negedge clk);
        issue('{1, 32'h40, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0BADF00D, "w3 rd after rst"});

        // Busy transfers carrying a write must not touch memory.
        @(negedge clk);
        d_addr[2]  = 32'h8;
        d_wdata[2] = 32'hFFFFFFFF;
        d_write[2] = 1'b1;
        d_size[2]  = 1'b1;
        d_trans[2] = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("w0 busy ready %0d", c), 32'(q_ready[2]), 32'd0);
        end

        // Held request with zero wait states: sample, DATA, ready, ignored, sample, ...
        d_write[2] = 1'b0;
        d_trans[2] = 2'b10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("w0 b2b ready %0d", c), 32'(q_ready[2]), 32'((c % 3) == 1));
        end
        d_trans[2] = 2'b00;
        chk("w0 b2b rdata", q_rdata[2], 32'h5A5A0001);
        chk("w0 b2b abort", 32'(q_abort[2]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
